// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef logic [31:0] dataBus_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2
  } arbState_t;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } arbPort_t;

  // Everything driven onto the memory bus besides req, latched at grant.
  typedef struct packed {
    logic       we;
    logic [3:0] be;
    dataBus_t   addr;
    dataBus_t   wdata;
  } mem_cmd_t;

  localparam int unsigned WDOG_W = 16;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Saturating ack watchdog: counts busy cycles since the last grant.
module mem_ack_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WDOG_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && cnt != '1)  cnt <= cnt + 1'b1;
  end

  // Zero in the first req cycle, so the abort lands in req cycle ACK_TIMEOUT+1.
  assign expired = (cnt >= WDOG_W'(ACK_TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data-access requests onto one req/ack memory bus.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  i_inst_rd_en,
  input  dataBus_t    i_inst_addr,
  output logic        o_instr_ready,
  output dataBus_t    o_instr_data,
  input  logic        i_data_rd_en_ma,
  input  logic        i_data_wr_en_ma,
  input  logic [3:0]  i_data_rd_en_ctrl,
  input  dataBus_t    i_data_addr,
  input  dataBus_t    i_data_wr,
  output logic        o_data_ready,
  output dataBus_t    o_data_rd,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output dataBus_t    o_mem_addr,
  output dataBus_t    o_mem_wdata,
  input  logic        i_mem_ack,
  input  dataBus_t    i_mem_rdata,
  output logic        o_bus_err
);

  arbState_t state;
  arbPort_t  last_grant;
  mem_cmd_t  cmd_q, grant_cmd;
  logic      instr_done, data_done;
  logic      inst_req, data_req, inst_pend, data_pend;
  logic      grant_i, grant_d, busy, expired, ack_hit, timeout, finish;
  dataBus_t  rdata_fin;

  assign inst_req  = |i_inst_rd_en;
  assign data_req  = i_data_rd_en_ma | i_data_wr_en_ma;
  assign inst_pend = inst_req & ~instr_done & (state != INSTR);
  assign data_pend = data_req & ~data_done  & (state != DATA);

  // Data normally wins, but never twice in a row against a waiting fetch.
  assign grant_i = (state == IDLE) & inst_pend & (~data_pend | (last_grant == PORT_DATA));
  assign grant_d = (state == IDLE) & data_pend & ~grant_i;

  assign busy      = (state != IDLE);
  assign ack_hit   = busy & i_mem_ack;
  assign timeout   = busy & ~i_mem_ack & expired;
  assign finish    = ack_hit | timeout;
  assign rdata_fin = ack_hit ? i_mem_rdata : '0;

  always_comb begin
    grant_cmd = cmd_q;
    if (grant_i) begin
      grant_cmd.we   = 1'b0;
      grant_cmd.be   = i_inst_rd_en;
      grant_cmd.addr = i_inst_addr;
    end else if (grant_d) begin
      grant_cmd.we    = i_data_wr_en_ma;
      grant_cmd.be    = i_data_rd_en_ctrl;
      grant_cmd.addr  = i_data_addr;
      grant_cmd.wdata = i_data_wr;
    end
  end

  mem_ack_watchdog #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant_i | grant_d),
    .en      (busy),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= PORT_DATA;
      cmd_q        <= '0;
      o_mem_req    <= 1'b0;
      instr_done   <= 1'b0;
      data_done    <= 1'b0;
      o_bus_err    <= 1'b0;
      o_instr_data <= '0;
      o_data_rd    <= '0;
    end else begin
      instr_done <= 1'b0;
      data_done  <= 1'b0;
      o_bus_err  <= 1'b0;
      cmd_q      <= grant_cmd;
      case (state)
        IDLE: begin
          if (grant_i) begin
            state      <= INSTR;
            o_mem_req  <= 1'b1;
            last_grant <= PORT_INSTR;
          end else if (grant_d) begin
            state      <= DATA;
            o_mem_req  <= 1'b1;
            last_grant <= PORT_DATA;
          end
        end
        INSTR: begin
          if (finish) begin
            o_instr_data <= rdata_fin;
            instr_done   <= 1'b1;
            o_bus_err    <= timeout;
            o_mem_req    <= 1'b0;
            state        <= IDLE;
          end
        end
        DATA: begin
          if (finish) begin
            if (!cmd_q.we) o_data_rd <= rdata_fin;
            data_done <= 1'b1;
            o_bus_err <= timeout;
            o_mem_req <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          o_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_we    = cmd_q.we;
  assign o_mem_be    = cmd_q.be;
  assign o_mem_addr  = cmd_q.addr;
  assign o_mem_wdata = cmd_q.wdata;

  // A waiting or in-flight requester sees 0; the done pulse reports completion.
  assign o_instr_ready = instr_done | (~inst_req & (state != INSTR));
  assign o_data_ready  = data_done  | (~data_req & (state != DATA));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  i_inst_rd_en;
  dataBus_t    i_inst_addr;
  logic        o_instr_ready;
  dataBus_t    o_instr_data;
  logic        i_data_rd_en_ma, i_data_wr_en_ma;
  logic [3:0]  i_data_rd_en_ctrl;
  dataBus_t    i_data_addr, i_data_wr;
  logic        o_data_ready;
  dataBus_t    o_data_rd;
  logic        o_mem_req, o_mem_we;
  logic [3:0]  o_mem_be;
  dataBus_t    o_mem_addr, o_mem_wdata;
  logic        i_mem_ack;
  dataBus_t    i_mem_rdata;
  logic        o_bus_err;

  always #5 clk = ~clk;

  mem_arbiter #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .i_inst_rd_en(i_inst_rd_en), .i_inst_addr(i_inst_addr),
    .o_instr_ready(o_instr_ready), .o_instr_data(o_instr_data),
    .i_data_rd_en_ma(i_data_rd_en_ma), .i_data_wr_en_ma(i_data_wr_en_ma),
    .i_data_rd_en_ctrl(i_data_rd_en_ctrl), .i_data_addr(i_data_addr),
    .i_data_wr(i_data_wr), .o_data_ready(o_data_ready), .o_data_rd(o_data_rd),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_bus_err(o_bus_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus (0 none, 1 fetch, 2 data), how long it has waited,
  // who won last, and the bus/port values that must be visible.
  int         m_owner, m_age, m_last;
  bit         m_done_i, m_done_d, m_req, m_we, m_err;
  logic [3:0] m_be;
  dataBus_t   m_addr, m_wdata, m_idata, m_drd;

  task automatic model_reset();
    m_owner = 0; m_age = 0; m_last = 2;
    m_done_i = 0; m_done_d = 0; m_req = 0; m_we = 0; m_err = 0;
    m_be = '0; m_addr = '0; m_wdata = '0; m_idata = '0; m_drd = '0;
  endtask

  task automatic model_step();
    bit nd_i, nd_d, pi, pd;
    nd_i = 0; nd_d = 0; m_err = 0;
    if (m_owner != 0) begin
      if (i_mem_ack || m_age >= int'(T)) begin
        if (m_owner == 1) begin
          m_idata = i_mem_ack ? i_mem_rdata : 32'h0;
          nd_i = 1;
        end else begin
          if (!m_we) m_drd = i_mem_ack ? i_mem_rdata : 32'h0;
          nd_d = 1;
        end
        m_err   = !i_mem_ack;
        m_owner = 0;
      end else if (m_age < 65535) begin
        m_age++;
      end
    end else begin
      pi = (i_inst_rd_en != 0) && !m_done_i;
      pd = (i_data_rd_en_ma || i_data_wr_en_ma) && !m_done_d;
      if (pi && (!pd || m_last == 2)) begin
        m_owner = 1; m_last = 1; m_age = 0;
        m_we = 0; m_be = i_inst_rd_en; m_addr = i_inst_addr;
      end else if (pd) begin
        m_owner = 2; m_last = 2; m_age = 0;
        m_we = i_data_wr_en_ma; m_be = i_data_rd_en_ctrl;
        m_addr = i_data_addr; m_wdata = i_data_wr;
      end
    end
    m_req = (m_owner != 0);
    m_done_i = nd_i; m_done_d = nd_d;
  endtask

  task automatic check_regs();
    chk1("mem_req", o_mem_req, m_req);
    chk1("mem_we", o_mem_we, m_we);
    chk("mem_be", {28'h0, o_mem_be}, {28'h0, m_be});
    chk("mem_addr", o_mem_addr, m_addr);
    chk("mem_wdata", o_mem_wdata, m_wdata);
    chk("instr_data", o_instr_data, m_idata);
    chk("data_rd", o_data_rd, m_drd);
    chk1("bus_err", o_bus_err, m_err);
  endtask

  task automatic check_ready();
    chk1("instr_ready", o_instr_ready, m_done_i || (i_inst_rd_en == 0 && m_owner != 1));
    chk1("data_ready", o_data_ready,
         m_done_d || (!(i_data_rd_en_ma || i_data_wr_en_ma) && m_owner != 2));
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic tick();
    #1 check_ready();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  task automatic idle_inputs();
    i_inst_rd_en = '0; i_inst_addr = '0;
    i_data_rd_en_ma = 0; i_data_wr_en_ma = 0; i_data_rd_en_ctrl = '0;
    i_data_addr = '0; i_data_wr = '0; i_mem_ack = 0; i_mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs(); model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int n, errs;
    dataBus_t seq[$];
    bit found;

    rst = 1; idle_inputs(); model_reset();
    repeat (2) @(negedge clk);
    check_regs();
    #1;
    chk1("rst_instr_ready", o_instr_ready, 1'b1);
    chk1("rst_data_ready", o_data_ready, 1'b1);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    rst = 0;

    // Fetch only, ack in the third req cycle.
    i_inst_rd_en = 4'hF; i_inst_addr = 32'h0000_0040;
    tick();
    chk1("fetch_we", o_mem_we, 1'b0);
    chk("fetch_addr", o_mem_addr, 32'h40);
    n = 0;
    while (o_mem_req === 1'b1 && n < 10) begin
      n++;
      i_mem_ack   = (n == 3);
      i_mem_rdata = (n == 3) ? 32'h0010_0093 : $urandom;
      tick();
    end
    i_mem_ack = 0;
    chk("fetch_req_cycles", n, 3);
    #1;
    chk1("fetch_ready", o_instr_ready, 1'b1);
    chk("fetch_data", o_instr_data, 32'h0010_0093);
    i_inst_rd_en = 0;
    tick();

    // Simultaneous fetch and load right after reset: fetch goes first.
    do_reset();
    i_inst_rd_en = 4'hF; i_inst_addr = 32'h100;
    i_data_rd_en_ma = 1; i_data_rd_en_ctrl = 4'hF; i_data_addr = 32'h2000;
    tick();
    chk("sim_first_addr", o_mem_addr, 32'h100);
    i_mem_ack = 1; i_mem_rdata = 32'h1111_2222;
    tick();
    i_mem_ack = 0;
    #1 chk1("sim_data_wait", o_data_ready, 1'b0);
    i_inst_rd_en = 0;
    tick();
    chk("sim_second_addr", o_mem_addr, 32'h2000);
    chk1("sim_data_inflight", o_data_ready, 1'b0);
    i_mem_ack = 1; i_mem_rdata = 32'h1234_5678;
    tick();
    i_mem_ack = 0;
    #1;
    chk1("sim_data_ready", o_data_ready, 1'b1);
    chk("sim_data_rd", o_data_rd, 32'h1234_5678);
    i_data_rd_en_ma = 0;
    tick();

    // Fairness: both ports held, memory always acks at once.
    i_inst_rd_en = 4'hF; i_inst_addr = 32'h500;
    i_data_rd_en_ma = 1; i_data_addr = 32'h600;
    i_mem_ack = 1; i_mem_rdata = 32'hA5A5_0001;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (o_mem_req === 1'b1) seq.push_back(o_mem_addr);
    end
    chk1("fair_count", seq.size() >= 4, 1'b1);
    if (seq.size() > 0) chk("fair_first", seq[0], 32'h500);
    for (int k = 1; k < seq.size(); k++) chk1("fair_alternate", seq[k] != seq[k-1], 1'b1);
    idle_inputs(); i_mem_ack = 1;
    repeat (3) tick();
    i_mem_ack = 0;

    // Store with immediate ack leaves the read register alone.
    i_data_wr_en_ma = 1; i_data_addr = 32'h3004; i_data_wr = 32'hDEAD_BEEF;
    i_data_rd_en_ctrl = 4'h3;
    tick();
    chk1("st_we", o_mem_we, 1'b1);
    chk("st_be", {28'h0, o_mem_be}, 32'h3);
    chk("st_addr", o_mem_addr, 32'h3004);
    chk("st_wdata", o_mem_wdata, 32'hDEAD_BEEF);
    i_mem_ack = 1; i_mem_rdata = 32'h5555_5555;
    tick();
    i_mem_ack = 0;
    #1;
    chk1("st_ready", o_data_ready, 1'b1);
    chk("st_data_rd", o_data_rd, 32'hA5A5_0001);
    i_data_wr_en_ma = 0;
    tick();

    // Timeout: read with no ack at all.
    i_data_rd_en_ma = 1; i_data_addr = 32'h44; i_data_rd_en_ctrl = 4'hF;
    found = 0; n = 0;
    while (!found && n < 20) begin
      tick(); n++;
      found = (o_bus_err === 1'b1);
    end
    chk1("to_err_seen", found, 1'b1);
    chk("to_cycles", n, T + 2);
    chk("to_data", o_data_rd, 32'h0);
    i_data_rd_en_ma = 0;
    errs = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (o_bus_err === 1'b1) errs++;
    end
    chk("to_single_pulse", errs, 0);
    i_data_rd_en_ma = 1; i_data_addr = 32'h48;
    tick(); tick();
    i_mem_ack = 1; i_mem_rdata = 32'h0000_0077;
    tick();
    i_mem_ack = 0; i_data_rd_en_ma = 0;
    chk("to_after_data", o_data_rd, 32'h77);
    tick();

    // Reset in the middle of a data transfer.
    i_data_rd_en_ma = 1; i_data_addr = 32'h80;
    tick();
    chk1("mid_req_before", o_mem_req, 1'b1);
    #2 rst = 1;
    #1;
    chk1("mid_req", o_mem_req, 1'b0);
    chk("mid_addr", o_mem_addr, 32'h0);
    chk("mid_data_rd", o_data_rd, 32'h0);
    chk("mid_instr_data", o_instr_data, 32'h0);
    model_reset(); idle_inputs();
    @(negedge clk);
    rst = 0;
    check_regs();

    // Random traffic, including acks while idle and occasional timeouts.
    for (int c = 0; c < 3000; c++) begin
      if (!(i_inst_rd_en != 0 && !m_done_i)) begin
        if ($urandom_range(0, 3) != 0) begin
          i_inst_rd_en = 4'($urandom_range(1, 15)); i_inst_addr = $urandom;
        end else i_inst_rd_en = 0;
      end
      if (!((i_data_rd_en_ma || i_data_wr_en_ma) && !m_done_d)) begin
        n = $urandom_range(0, 3);
        i_data_rd_en_ma = (n == 1 || n == 3);
        i_data_wr_en_ma = (n == 2 || n == 3);
        i_data_rd_en_ctrl = 4'($urandom_range(0, 15));
        i_data_addr = $urandom; i_data_wr = $urandom;
      end
      i_mem_ack   = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      i_mem_rdata = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
